multi_channel_raster_sequencer: RTL

- Parametrised successor of the dual-image stream driving path: merges CHANNELS independent ready/valid pixel streams into one lock-stepped raster stream.
- Each output beat carries all channels plus col_o/row_o/valid_o, with frame markers and optional horizontal/vertical blanking.
- Sits in front of dual_scale_wrapper_fp16 (or its N-scale successors) and replaces the bench-side dual-image driver in hardware builds.
- Adds behaviour the dual driver lacks: N channels, programmable blanking, continuous/one-shot modes, abort, stall accounting.

---
 rtl/multi_channel_raster_sequencer_if.sv | 39 +++
 rtl/multi_channel_raster_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_raster_sequencer_if.sv
// Bus bundle for the raster sequencer: control, per-channel input streams,
// the merged raster output and status counters.
interface multi_channel_raster_sequencer_if #(
  parameter int CHANNELS    = 2,
  parameter int DATA_WIDTH  = 16,
  parameter int CNT_WIDTH   = 16,
  parameter int STALL_WIDTH = 32
);
  logic                                start_i;
  logic                                continuous_i;
  logic                                abort_i;
  logic [CHANNELS-1:0][DATA_WIDTH-1:0] data_i;
  logic [CHANNELS-1:0]                 valid_i;
  logic [CHANNELS-1:0]                 ready_o;
  logic [CHANNELS-1:0][DATA_WIDTH-1:0] data_o;
  logic [CNT_WIDTH-1:0]                col_o;
  logic [CNT_WIDTH-1:0]                row_o;
  logic                                valid_o;
  logic                                sof_o;
  logic                                eol_o;
  logic                                eof_o;
  logic                                busy_o;
  logic [CNT_WIDTH-1:0]                frame_count_o;
  logic [STALL_WIDTH-1:0]              stall_count_o;

  // Driver side: issues commands and pixel streams, observes the raster.
  modport master (
    output start_i, continuous_i, abort_i, data_i, valid_i,
    input  ready_o, data_o, col_o, row_o, valid_o, sof_o, eol_o, eof_o,
           busy_o, frame_count_o, stall_count_o
  );

  // Sequencer side.
  modport slave (
    input  start_i, continuous_i, abort_i, data_i, valid_i,
    output ready_o, data_o, col_o, row_o, valid_o, sof_o, eol_o, eof_o,
           busy_o, frame_count_o, stall_count_o
  );
endinterface

// File: rtl/multi_channel_raster_sequencer.sv
// Merges CHANNELS ready/valid pixel streams into one lock-stepped raster
// stream with column/row tags, frame markers and optional H/V blanking.

// One pixel lane: captures its channel's pixel on an accepted beat and
// holds it between beats.
module mcrs_lane #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);
  // Capture on accept, hold otherwise
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)    dout <= '0;
    else if (load) dout <= din;
  end
endmodule

module multi_channel_raster_sequencer #(
  parameter int CHANNELS     = 2,
  parameter int DATA_WIDTH   = 16,
  parameter int IMAGE_WIDTH  = 512,
  parameter int IMAGE_HEIGHT = 400,
  parameter int H_BLANK      = 0,
  parameter int V_BLANK      = 0,
  parameter int CNT_WIDTH    = 16,
  parameter int STALL_WIDTH  = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  multi_channel_raster_sequencer_if.slave bus
);
  localparam logic [CNT_WIDTH-1:0] COL_LAST = CNT_WIDTH'(IMAGE_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] ROW_LAST = CNT_WIDTH'(IMAGE_HEIGHT - 1);
  // Blank counters run 0..N-1; clamp so a zero-length blank stays legal.
  localparam logic [CNT_WIDTH-1:0] HB_LAST  = CNT_WIDTH'((H_BLANK > 0) ? H_BLANK - 1 : 0);
  localparam logic [CNT_WIDTH-1:0] VB_LAST  = CNT_WIDTH'((V_BLANK > 0) ? V_BLANK - 1 : 0);

  typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_t;

  typedef struct packed {
    logic [CNT_WIDTH-1:0] col;
    logic [CNT_WIDTH-1:0] row;
    logic                 sof;
    logic                 eol;
    logic                 eof;
  } beat_t;

  state_t                              state;
  logic [CNT_WIDTH-1:0]                col, row, blank_cnt;
  logic                                all_valid, accept, row_end, frame_end;
  beat_t                               beat_next, beat_q;
  logic                                valid_q;
  logic [CNT_WIDTH-1:0]                frame_count;
  logic [STALL_WIDTH-1:0]              stall_count;
  logic [CHANNELS-1:0][DATA_WIDTH-1:0] data_q;

  // Join: a beat moves only when every channel offers a pixel, and abort
  // blocks acceptance in its own cycle so no channel is consumed alone.
  assign all_valid   = &bus.valid_i;
  assign accept      = (state == ACTIVE) && all_valid && !bus.abort_i;
  assign row_end     = (col == COL_LAST);
  assign frame_end   = row_end && (row == ROW_LAST);
  assign bus.ready_o = {CHANNELS{accept}};

  assign beat_next.col = col;
  assign beat_next.row = row;
  assign beat_next.sof = (col == '0) && (row == '0);
  assign beat_next.eol = row_end;
  assign beat_next.eof = frame_end;

  // Sequencer FSM: raster position, blanking and frame re-arm
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      blank_cnt <= '0;
    end else if (bus.abort_i) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      blank_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            state <= ACTIVE;
            col   <= '0;
            row   <= '0;
          end
        end
        ACTIVE: begin
          if (accept) begin
            if (!row_end) begin
              col <= col + 1'b1;
            end else if (!frame_end) begin
              col       <= '0;
              row       <= row + 1'b1;
              blank_cnt <= '0;
              if (H_BLANK > 0) state <= HBLANK;
            end else begin
              col       <= '0;
              row       <= '0;
              blank_cnt <= '0;
              // With no vertical blank, continuous_i is sampled on the last beat
              if (V_BLANK > 0)            state <= VBLANK;
              else if (!bus.continuous_i) state <= IDLE;
            end
          end
        end
        HBLANK: begin
          if (blank_cnt == HB_LAST) begin
            blank_cnt <= '0;
            state     <= ACTIVE;
          end else begin
            blank_cnt <= blank_cnt + 1'b1;
          end
        end
        VBLANK: begin
          if (blank_cnt == VB_LAST) begin
            blank_cnt <= '0;
            state     <= bus.continuous_i ? ACTIVE : IDLE;
          end else begin
            blank_cnt <= blank_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output beat register: markers pulse only with a beat, position holds
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= 1'b0;
      beat_q  <= '0;
    end else begin
      valid_q <= accept;
      if (accept) begin
        beat_q <= beat_next;
      end else begin
        beat_q.sof <= 1'b0;
        beat_q.eol <= 1'b0;
        beat_q.eof <= 1'b0;
      end
    end
  end

  // Status: frame count steps with the eof beat; stall count saturates
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      frame_count <= '0;
      stall_count <= '0;
    end else begin
      if (accept && frame_end)
        frame_count <= frame_count + 1'b1;
      if ((state == ACTIVE) && !all_valid && (stall_count != '1))
        stall_count <= stall_count + 1'b1;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    mcrs_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .load  (accept),
      .din   (bus.data_i[c]),
      .dout  (data_q[c])
    );
  end

  assign bus.data_o        = data_q;
  assign bus.valid_o       = valid_q;
  assign bus.col_o         = beat_q.col;
  assign bus.row_o         = beat_q.row;
  assign bus.sof_o         = beat_q.sof;
  assign bus.eol_o         = beat_q.eol;
  assign bus.eof_o         = beat_q.eof;
  assign bus.busy_o        = (state != IDLE);
  assign bus.frame_count_o = frame_count;
  assign bus.stall_count_o = stall_count;
endmodule
